// File: rtl/adder_unit.sv
// Registered WIDTH-bit adder built from 4-bit carry-lookahead groups; 1-cycle latency.
// No back-pressure: a new operand set is accepted on every edge with IN_VALID high.
module adder_unit #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             IN_VALID,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C_IN,
  output logic             OUT_VALID,
  output logic [WIDTH-1:0] SUM,
  output logic             C_OUT,
  output logic             OVF,
  output logic             ZERO
);

  localparam int NGRP = WIDTH / 4;

  // carry[i] is the carry into bit i; carry[WIDTH] is the final carry out
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_c;

  assign carry[0] = C_IN;

  for (genvar gi = 0; gi < NGRP; gi++) begin : g_cla
    logic [3:0] gen;
    logic [3:0] prop;
    logic [3:0] cb;
    logic       grp_g;
    logic       grp_p;

    assign gen  = A[4*gi +: 4] & B[4*gi +: 4];
    assign prop = A[4*gi +: 4] ^ B[4*gi +: 4];

    assign cb[0] = carry[4*gi];
    assign cb[1] = gen[0] | (prop[0] & cb[0]);
    assign cb[2] = gen[1] | (prop[1] & gen[0]) | (prop[1] & prop[0] & cb[0]);
    assign cb[3] = gen[2] | (prop[2] & gen[1]) | (prop[2] & prop[1] & gen[0])
                 | (prop[2] & prop[1] & prop[0] & cb[0]);

    assign grp_g = gen[3] | (prop[3] & gen[2]) | (prop[3] & prop[2] & gen[1])
                 | (prop[3] & prop[2] & prop[1] & gen[0]);
    assign grp_p = &prop;

    // Group carry ripples into the next group
    assign carry[4*gi+1 +: 3] = cb[3:1];
    assign carry[4*gi+4]      = grp_g | (grp_p & cb[0]);
    assign sum_c[4*gi +: 4]   = prop ^ cb;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      OUT_VALID <= 1'b0;
      SUM       <= '0;
      C_OUT     <= 1'b0;
      OVF       <= 1'b0;
      ZERO      <= 1'b1;
    end else begin
      OUT_VALID <= IN_VALID;
      if (IN_VALID) begin
        SUM   <= sum_c;
        C_OUT <= carry[WIDTH];
        OVF   <= carry[WIDTH] ^ carry[WIDTH-1];
        ZERO  <= ~|sum_c;
      end
    end
  end

endmodule

// File: tb/tb_adder_unit.sv
// Scoreboarded bench for adder_unit: stimulus pushes expected results, a negedge monitor pops and compares.
module tb_adder_unit;

  localparam int W = 32;

  logic         CLK;
  logic         RESET;
  logic         IN_VALID;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         C_IN;
  logic         OUT_VALID;
  logic [W-1:0] SUM;
  logic         C_OUT;
  logic         OVF;
  logic         ZERO;

  adder_unit #(.WIDTH(W)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .IN_VALID  (IN_VALID),
    .A         (A),
    .B         (B),
    .C_IN      (C_IN),
    .OUT_VALID (OUT_VALID),
    .SUM       (SUM),
    .C_OUT     (C_OUT),
    .OVF       (OVF),
    .ZERO      (ZERO)
  );

  typedef struct packed {
    logic [W-1:0] s;
    logic         c;
    logic         o;
    logic         z;
  } exp_t;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    exp_t         e;
  } vec_t;

  vec_t vec [10];
  exp_t sb_q [$];
  int   errors = 0;
  int   checks = 0;
  int   pushed = 0;
  int   seen   = 0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One cycle of stimulus; inputs are scrambled after the edge to show only edge values matter
  task automatic step(input logic rst, input logic vld, input int idx);
    @(negedge CLK);
    RESET    = rst;
    IN_VALID = vld;
    A        = vec[idx].a;
    B        = vec[idx].b;
    C_IN     = vec[idx].ci;
    if (vld && !rst) begin
      sb_q.push_back(vec[idx].e);
      pushed++;
    end
    @(posedge CLK);
    #2;
    A    = ~A;
    B    = B ^ 32'h5A5A_A5A5;
    C_IN = ~C_IN;
  endtask

  task automatic check_reset_state(input string name);
    check(name, {31'd0, OUT_VALID, SUM, C_OUT, OVF, ZERO},
                {31'd0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1});
  endtask

  always @(negedge CLK) begin
    if (OUT_VALID === 1'b1) begin
      seen++;
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got sum=%0h with empty scoreboard", SUM);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("result", {29'd0, SUM, C_OUT, OVF, ZERO}, {29'd0, e.s, e.c, e.o, e.z});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    //         a              b              ci    sum            c     o     z
    vec[0] = '{32'h0000_00F1, 32'h0000_00B1, 1'b0, '{32'h0000_01A2, 1'b0, 1'b0, 1'b0}};
    vec[1] = '{32'hC0F0_F002, 32'h0000_00F1, 1'b0, '{32'hC0F0_F0F3, 1'b0, 1'b0, 1'b0}};
    vec[2] = '{32'hF0F0_F002, 32'h4000_00F1, 1'b0, '{32'h30F0_F0F3, 1'b1, 1'b0, 1'b0}};
    vec[3] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, '{32'h8000_0000, 1'b0, 1'b1, 1'b0}};
    vec[4] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, '{32'h0000_0000, 1'b1, 1'b0, 1'b1}};
    vec[5] = '{32'h8000_0000, 32'h8000_0000, 1'b0, '{32'h0000_0000, 1'b1, 1'b1, 1'b1}};
    vec[6] = '{32'h1234_5678, 32'h0000_0000, 1'b1, '{32'h1234_5679, 1'b0, 1'b0, 1'b0}};
    vec[7] = '{32'h0000_0000, 32'h0000_0000, 1'b0, '{32'h0000_0000, 1'b0, 1'b0, 1'b1}};
    vec[8] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, '{32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0}};
    vec[9] = '{32'h0F0F_0F0F, 32'hF0F0_F0F0, 1'b1, '{32'h0000_0000, 1'b1, 1'b0, 1'b1}};

    RESET    = 1'b1;
    IN_VALID = 1'b0;
    A        = '0;
    B        = '0;
    C_IN     = 1'b0;

    step(1'b1, 1'b0, 0);
    check_reset_state("reset_state");
    // Valid operands on a reset edge are discarded
    step(1'b1, 1'b1, 0);
    check_reset_state("reset_priority");

    // Back-to-back basic, neg+pos and carry-out vectors
    step(1'b0, 1'b1, 0);
    step(1'b0, 1'b1, 1);
    step(1'b0, 1'b1, 2);

    // Idle cycles hold the last result with OUT_VALID low
    step(1'b0, 1'b0, 5);
    check("idle_hold1", {30'd0, OUT_VALID, SUM, C_OUT, OVF, ZERO},
                        {30'd0, 1'b0, 32'h30F0_F0F3, 1'b1, 1'b0, 1'b0});
    step(1'b0, 1'b0, 3);
    check("idle_hold2", {30'd0, OUT_VALID, SUM, C_OUT, OVF, ZERO},
                        {30'd0, 1'b0, 32'h30F0_F0F3, 1'b1, 1'b0, 1'b0});

    step(1'b1, 1'b0, 0);
    check_reset_state("reset_after_idle");

    for (int i = 3; i < 10; i++) step(1'b0, 1'b1, i);

    // Mid-stream reset discards the operands presented on the reset edge
    step(1'b0, 1'b1, 6);
    step(1'b1, 1'b1, 8);
    check_reset_state("reset_midstream");

    step(1'b0, 1'b1, 2);
    step(1'b0, 1'b0, 0);
    step(1'b0, 1'b0, 0);

    check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    check("result_count", 64'(seen), 64'(pushed));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
